udp_send_arbiter: RTL and testbench

- Shares one UPL UDP send port of the e7udpip core between two packet sources, e.g. the simple_udprecv responder and a status/telemetry generator.
- Each source sees a full UPL sender interface (Request/Ack/Enable/Data).
- The arbiter grants one source per packet with round-robin priority, forwards the handshake and streams the packet to the core's pUdp0Send port with registered outputs.

---
 rtl/udp_send_arbiter.sv | 132 +++++++++++++
 tb/tb_udp_send_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/udp_send_arbiter.sv
// udp_send_arbiter: round-robin share of one UPL UDP send port between two packet sources.
// Optional XFER stall timeout with timeout_err output when UDP_SEND_ARBITER_TIMEOUT_EN is defined.
module udp_send_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              UPLin0_Request,
  output logic              UPLin0_Ack,
  input  logic              UPLin0_Enable,
  input  logic [DATA_W-1:0] UPLin0_Data,
  input  logic              UPLin1_Request,
  output logic              UPLin1_Ack,
  input  logic              UPLin1_Enable,
  input  logic [DATA_W-1:0] UPLin1_Data,
  output logic              UPLout_Request,
  input  logic              UPLout_Ack,
  output logic              UPLout_Enable,
  output logic [DATA_W-1:0] UPLout_Data,
`ifdef UDP_SEND_ARBITER_TIMEOUT_EN
  output logic              timeout_err,
`endif
  output logic              grant,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;
  state_t state_q, state_d;
  logic grant_q, grant_d, last_q, last_d, seen_q, seen_d;
  logic req_q, req_d, ack0_q, ack0_d, ack1_q, ack1_d, en_q, en_d, busy_q, busy_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic sel_en;
  logic [DATA_W-1:0] sel_data;
`ifdef UDP_SEND_ARBITER_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic tout_q, tout_d;
`endif
  assign sel_en   = grant_q ? UPLin1_Enable : UPLin0_Enable;
  assign sel_data = grant_q ? UPLin1_Data : UPLin0_Data;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    seen_d  = seen_q;
    req_d   = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    en_d    = 1'b0;
    data_d  = data_q;
    case (state_q)
      IDLE: if (UPLin0_Request || UPLin1_Request) begin
        grant_d = (UPLin0_Request && UPLin1_Request) ? ~last_q : UPLin1_Request;
        req_d   = 1'b1;
        state_d = REQ;
      end
      REQ: if (UPLout_Ack) begin
        ack0_d  = ~grant_q;
        ack1_d  = grant_q;
        seen_d  = 1'b0;
        state_d = XFER;
      end else req_d = 1'b1;
      XFER: begin
        en_d = sel_en;
        if (sel_en) begin
          data_d = sel_data;
          seen_d = 1'b1;
        end
        // idle cycles before the first word are a legal wait, not a packet end
        if (seen_q && !sel_en) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef UDP_SEND_ARBITER_TIMEOUT_EN
    cnt_d  = (state_q == XFER && !sel_en) ? cnt_q + 16'd1 : 16'd0;
    tout_d = 1'b0;
    if (state_q == XFER && !sel_en && cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
      en_d    = 1'b0;
      state_d = IDLE;
      last_d  = grant_q;
      tout_d  = 1'b1;
    end
`endif
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      seen_q  <= 1'b0;
      req_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      en_q    <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      seen_q  <= seen_d;
      req_q   <= req_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      en_q    <= en_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end
`ifdef UDP_SEND_ARBITER_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tout_q <= tout_d;
    end
  end
  assign timeout_err = tout_q;
`endif
  assign UPLout_Request = req_q;
  assign UPLout_Enable  = en_q;
  assign UPLout_Data    = data_q;
  assign UPLin0_Ack     = ack0_q;
  assign UPLin1_Ack     = ack1_q;
  assign grant          = grant_q;
  assign busy           = busy_q;
endmodule

// File: tb/tb_udp_send_arbiter.sv
// tb_udp_send_arbiter: directed scoreboard bench for udp_send_arbiter (default build).
module tb_udp_send_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic req[2];
  logic en[2];
  logic [31:0] dat[2];
  logic out_ack;
  logic ack0, ack1, out_req, out_en, grant, busy;
  logic [31:0] out_data;
  int tests = 0;
  int fails = 0;
  int out_cnt = 0;
  int ack_cnt[2];
  logic [31:0] q[$];

  udp_send_arbiter #(.TIMEOUT_CYCLES(16), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .UPLin0_Request(req[0]), .UPLin0_Ack(ack0), .UPLin0_Enable(en[0]), .UPLin0_Data(dat[0]),
    .UPLin1_Request(req[1]), .UPLin1_Ack(ack1), .UPLin1_Enable(en[1]), .UPLin1_Data(dat[1]),
    .UPLout_Request(out_req), .UPLout_Ack(out_ack), .UPLout_Enable(out_en), .UPLout_Data(out_data),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (ack0) ack_cnt[0]++;
      if (ack1) ack_cnt[1]++;
      if (out_en) begin
        out_cnt++;
        chk("word_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) chk("out_data", out_data, q.pop_front());
      end
    end
  end

  task automatic do_packet(input int src, input int n, input logic [31:0] base,
                           input int gap, input bit drop, input bit noise);
    int k = 0;
    int a0 = ack_cnt[0];
    int a1 = ack_cnt[1];
    out_cnt = 0;
    while (!out_req && k < 20) begin
      tick;
      k++;
    end
    chk("req_seen", 32'(out_req), 32'd1);
    chk("grant", 32'(grant), 32'(src));
    chk("busy_req", 32'(busy), 32'd1);
    tick;
    tick;
    chk("req_held", 32'(out_req), 32'd1);
    out_ack = 1'b1;
    tick;
    out_ack = 1'b0;
    chk("src_ack", 32'(src ? ack1 : ack0), 32'd1);
    chk("other_ack", 32'(src ? ack0 : ack1), 32'd0);
    chk("req_drop", 32'(out_req), 32'd0);
    if (drop) req[src] = 1'b0;
    tick;
    chk("ack_pulse", 32'(src ? ack1 : ack0), 32'd0);
    for (int i = 0; i < gap; i++) begin
      if (noise) begin
        en[1-src] = 1'($urandom);
        dat[1-src] = $urandom;
      end
      tick;
    end
    for (int i = 0; i < n; i++) begin
      en[src] = 1'b1;
      dat[src] = base + 32'(i);
      q.push_back(dat[src]);
      if (noise) begin
        en[1-src] = 1'($urandom);
        dat[1-src] = $urandom;
      end
      tick;
    end
    en[src] = 1'b0;
    tick;
    en[1-src] = 1'b0;
    chk("busy_end", 32'(busy), 32'd0);
    chk("word_count", 32'(out_cnt), 32'(n));
    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("ack0_count", 32'(ack_cnt[0]), 32'(a0 + (src == 0 ? 1 : 0)));
    chk("ack1_count", 32'(ack_cnt[1]), 32'(a1 + (src == 1 ? 1 : 0)));
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    reset = 1'b0;
  endtask

  initial begin
    int k;
    ack_cnt[0] = 0;
    ack_cnt[1] = 0;
    reset = 1'b1;
    req[0] = 1'b0; req[1] = 1'b0;
    en[0] = 1'b0; en[1] = 1'b0;
    dat[0] = '0; dat[1] = '0;
    out_ack = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    tick;
    chk("rst_req", 32'(out_req), 32'd0);
    chk("rst_en", 32'(out_en), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_acks", 32'({ack1, ack0}), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    req[0] = 1'b1;
    do_packet(0, 5, 32'h0A000001, 0, 1'b1, 1'b0);

    do_reset;
    req[0] = 1'b1;
    req[1] = 1'b1;
    do_packet(0, 3, 32'h10000000, 0, 1'b1, 1'b0);
    do_packet(1, 3, 32'h11000000, 0, 1'b1, 1'b0);

    req[0] = 1'b1;
    req[1] = 1'b1;
    do_packet(0, 2, 32'h20000000, 0, 1'b0, 1'b0);
    do_packet(1, 2, 32'h21000000, 0, 1'b0, 1'b0);
    do_packet(0, 2, 32'h22000000, 0, 1'b0, 1'b0);
    do_packet(1, 2, 32'h23000000, 0, 1'b0, 1'b0);
    req[0] = 1'b0;
    req[1] = 1'b0;
    tick;

    req[1] = 1'b1;
    do_packet(1, 4, 32'h30000000, 3, 1'b1, 1'b1);

    req[1] = 1'b1;
    k = 0;
    while (!out_req && k < 20) begin
      tick;
      k++;
    end
    chk("mid_req_seen", 32'(out_req), 32'd1);
    tick;
    tick;
    out_ack = 1'b1;
    tick;
    out_ack = 1'b0;
    req[1] = 1'b0;
    tick;
    en[1] = 1'b1;
    dat[1] = 32'h55;
    q.push_back(dat[1]);
    tick;
    dat[1] = 32'h56;
    req[0] = 1'b1;
    req[1] = 1'b1;
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_en", 32'(out_en), 32'd0);
    chk("mid_rst_req", 32'(out_req), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_grant", 32'(grant), 32'd0);
    q.delete();
    en[1] = 1'b0;
    tick;
    reset = 1'b0;
    do_packet(0, 2, 32'h40000000, 0, 1'b1, 1'b0);
    do_packet(1, 2, 32'h41000000, 0, 1'b1, 1'b0);
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
